// File: rtl/uart_mmio_responder.sv
// Memory-mapped responder between the LSU load/store port and a byte-level
// UART core. It holds TX/RX byte queues, status/control/baud registers and a
// registered level interrupt.
//
// Bus handshake: req is a one-cycle strobe. ack is a one-cycle pulse exactly
// one cycle after req. rdata is registered and is valid only while ack=1.
// All side effects (queue push/pop, W1C, register writes) commit on the clock
// edge that samples req.
module uart_mmio_responder #(
  parameter int          QDEPTH    = 4,
  parameter logic [15:0] BRD_RESET = 16'd5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [7:0]  tx_byte,
  output logic        tx_push,
  input  logic        tx_full,
  input  logic        rx_avail,
  output logic        rx_get,
  input  logic [9:0]  rx_frame,
  output logic [15:0] brd,
  output logic        irq
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_PUSH, TX_GAP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_GET, RX_CAP} rx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  rx_state_e   rx_state_q, rx_state_d;

  logic [7:0]  txq_mem_q [QDEPTH];
  logic [7:0]  txq_mem_d [QDEPTH];
  logic [7:0]  rxq_mem_q [QDEPTH];
  logic [7:0]  rxq_mem_d [QDEPTH];
  logic [PW-1:0] txq_wptr_q, txq_wptr_d, txq_rptr_q, txq_rptr_d;
  logic [PW-1:0] rxq_wptr_q, rxq_wptr_d, rxq_rptr_q, rxq_rptr_d;

  logic [4:0]  ctrl_q, ctrl_d;       // {ie_err, ie_tx, ie_rx, rx_en, tx_en}
  logic [15:0] brd_q, brd_d;
  logic [2:0]  sticky_q, sticky_d;   // {ferr, rxovf, txovf}
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_push_q, tx_push_d;
  logic        rx_get_q, rx_get_d;
  logic        irq_q, irq_d;

  // Address bits [1:0] and upper store-data bits carry no meaning here.
  logic        unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  logic [2:0]  sel;
  logic        tx_wr, rx_rd, st_wr, baud_wr, ctrl_wr;
  logic        txq_empty, txq_full, rxq_empty, rxq_full;
  logic        tx_pop, txq_push, txovf_set;
  logic        rx_pop, frame_ok, rxq_push, ferr_set, rxovf_set;
  logic [7:0]  status;

  assign sel     = addr[4:2];
  assign tx_wr   = req &  we & (sel == 3'd0);
  assign rx_rd   = req & ~we & (sel == 3'd1);
  assign st_wr   = req &  we & (sel == 3'd2);
  assign baud_wr = req &  we & (sel == 3'd3);
  assign ctrl_wr = req &  we & (sel == 3'd4);

  // Pointer MSB differs and index bits match: the queue is full.
  assign txq_empty = (txq_wptr_q == txq_rptr_q);
  assign txq_full  = (txq_wptr_q[AW] != txq_rptr_q[AW]) &&
                     (txq_wptr_q[AW-1:0] == txq_rptr_q[AW-1:0]);
  assign rxq_empty = (rxq_wptr_q == rxq_rptr_q);
  assign rxq_full  = (rxq_wptr_q[AW] != rxq_rptr_q[AW]) &&
                     (rxq_wptr_q[AW-1:0] == rxq_rptr_q[AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full queue is legal then.
  assign tx_pop    = (tx_state_q == TX_PUSH);
  assign txq_push  = tx_wr & (~txq_full | tx_pop);
  assign txovf_set = tx_wr & txq_full & ~tx_pop;

  assign rx_pop    = rx_rd & ~rxq_empty;
  assign frame_ok  = ~rx_frame[0] & rx_frame[9];
  assign rxq_push  = (rx_state_q == RX_CAP) & frame_ok & (~rxq_full | rx_pop);
  assign ferr_set  = (rx_state_q == RX_CAP) & ~frame_ok;
  assign rxovf_set = rx_avail & rxq_full & ctrl_q[1] & ~rx_pop;

  assign status = {(tx_state_q != TX_IDLE), sticky_q,
                   rxq_full, rxq_empty, txq_full, txq_empty};

  // Queue storage and pointers, plus register writes and sticky bits.
  always_comb begin
    txq_mem_d  = txq_mem_q;
    rxq_mem_d  = rxq_mem_q;
    txq_wptr_d = txq_wptr_q;
    txq_rptr_d = txq_rptr_q;
    rxq_wptr_d = rxq_wptr_q;
    rxq_rptr_d = rxq_rptr_q;
    if (txq_push) begin
      txq_mem_d[txq_wptr_q[AW-1:0]] = wdata[7:0];
      txq_wptr_d = txq_wptr_q + PW'(1);
    end
    if (tx_pop) txq_rptr_d = txq_rptr_q + PW'(1);
    if (rxq_push) begin
      rxq_mem_d[rxq_wptr_q[AW-1:0]] = rx_frame[8:1];
      rxq_wptr_d = rxq_wptr_q + PW'(1);
    end
    if (rx_pop) rxq_rptr_d = rxq_rptr_q + PW'(1);
    ctrl_d   = ctrl_wr ? wdata[4:0]  : ctrl_q;
    brd_d    = baud_wr ? wdata[15:0] : brd_q;
    // Set events win over a simultaneous write-one-to-clear.
    sticky_d = (sticky_q & ~(st_wr ? wdata[6:4] : 3'b000)) |
               {ferr_set, rxovf_set, txovf_set};
  end

  // Bus response: registered read data and a one-cycle ack.
  always_comb begin
    rdata_d = '0;
    ack_d   = req;
    if (req && !we) begin
      case (sel)
        3'd1:    if (!rxq_empty) rdata_d = {23'b0, 1'b1, rxq_mem_q[rxq_rptr_q[AW-1:0]]};
        3'd2:    rdata_d = {24'b0, status};
        3'd3:    rdata_d = {16'b0, brd_q};
        3'd4:    rdata_d = {27'b0, ctrl_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // TX FSM next state: one push, then a gap cycle so tx_full can update.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (ctrl_q[0] && !txq_empty && !tx_full) tx_state_d = TX_PUSH;
      TX_PUSH: tx_state_d = TX_GAP;
      TX_GAP:  tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX FSM outputs: strobe and byte registered alongside the PUSH state.
  always_comb begin
    tx_push_d = (tx_state_d == TX_PUSH);
    tx_byte_d = tx_push_d ? txq_mem_q[txq_rptr_q[AW-1:0]] : tx_byte_q;
  end

  // RX FSM next state: request a frame, capture it on the following cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (ctrl_q[1] && rx_avail && !rxq_full) rx_state_d = RX_GET;
      RX_GET:  rx_state_d = RX_CAP;
      RX_CAP:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FSM outputs and the interrupt level, built from registered state.
  always_comb begin
    rx_get_d = (rx_state_d == RX_GET);
    irq_d    = (ctrl_q[2] & ~rxq_empty) | (ctrl_q[3] & txq_empty) |
               (ctrl_q[4] & (|sticky_q));
  end

  // Queue payload storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    txq_mem_q <= txq_mem_d;
    rxq_mem_q <= rxq_mem_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      txq_wptr_q <= '0;
      txq_rptr_q <= '0;
      rxq_wptr_q <= '0;
      rxq_rptr_q <= '0;
      ctrl_q     <= '0;
      brd_q      <= BRD_RESET;
      sticky_q   <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      tx_byte_q  <= '0;
      tx_push_q  <= 1'b0;
      rx_get_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      txq_wptr_q <= txq_wptr_d;
      txq_rptr_q <= txq_rptr_d;
      rxq_wptr_q <= rxq_wptr_d;
      rxq_rptr_q <= rxq_rptr_d;
      ctrl_q     <= ctrl_d;
      brd_q      <= brd_d;
      sticky_q   <= sticky_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      tx_byte_q  <= tx_byte_d;
      tx_push_q  <= tx_push_d;
      rx_get_q   <= rx_get_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata   = rdata_q;
  assign ack     = ack_q;
  assign tx_byte = tx_byte_q;
  assign tx_push = tx_push_q;
  assign rx_get  = rx_get_q;
  assign brd     = brd_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder: register access, TX drain and
// overflow, RX capture, framing error, RX backpressure and mid-push reset.
module tb_uart_mmio_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic [7:0]  tx_byte;
  logic        tx_push;
  logic        tx_full;
  logic        rx_avail;
  logic        rx_get;
  logic [9:0]  rx_frame;
  logic [15:0] brd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int push_cnt = 0;
  int cyc      = 0;
  int last_push_cyc = -100;
  logic [7:0] exp_q[$];

  uart_mmio_responder #(.QDEPTH(4), .BRD_RESET(16'd5208)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .tx_byte(tx_byte), .tx_push(tx_push),
    .tx_full(tx_full), .rx_avail(rx_avail), .rx_get(rx_get),
    .rx_frame(rx_frame), .brd(brd), .irq(irq)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transmitter strobe must match the next expected byte
  always @(negedge clk) begin
    if (tx_push) begin
      push_cnt++;
      check("tx_push_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("tx_byte", {24'b0, tx_byte}, {24'b0, exp_q.pop_front()});
      check("tx_push_spacing", ((cyc - last_push_cyc) >= 2), 1);
      last_push_cyc = cyc;
    end
  end

  // Driver tasks
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    check("wr_ack", ack, 1);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    check("rd_ack", ack, 1);
    d = rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // Model the UART receiver: offer one frame, withdraw it once rx_get is seen
  task automatic rx_send(input logic [9:0] f);
    bit seen;
    seen = 0;
    @(negedge clk);
    rx_frame = f;
    rx_avail = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rx_get) begin
        seen = 1;
        break;
      end
    end
    rx_avail = 1'b0;
    check("rx_get_seen", seen, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("tx_drain_done", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int p0;
    int p1;
    int gets;
    bit found;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tx_full = 1'b0; rx_avail = 1'b0; rx_frame = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    check("rst_tx_push", tx_push, 0);
    check("rst_rx_get", rx_get, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_brd", brd, 32'd5208);
    rst = 1'b1;

    // Register map basics
    rd_chk("status_rst", 5'h08, 32'h0000_0005);
    rd_chk("baud_rst", 5'h0C, 32'h0000_1458);
    rd_chk("ctrl_rst", 5'h10, 32'h0);
    bus_write(5'h0C, 32'hABCD_1234);
    check("brd_out", brd, 32'h1234);
    rd_chk("baud_rw", 5'h0C, 32'h0000_1234);
    bus_write(5'h1C, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", 5'h14, 32'h0);
    rd_chk("baud_after_unmapped", 5'h0C, 32'h0000_1234);
    rd_chk("rxdata_empty_init", 5'h04, 32'h0);

    // TX drain
    bus_write(5'h10, 32'h01);
    p0 = push_cnt;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    bus_write(5'h00, 32'h41);
    bus_write(5'h00, 32'h42);
    wait_tx_drain();
    check("tx_drain_cnt", push_cnt - p0, 2);
    rd_chk("status_drained", 5'h08, 32'h0000_0005);

    // One good frame parked in the RX queue
    bus_write(5'h10, 32'h02);
    rx_send(10'b1_0101_0101_0);

    // TX overflow with transmitter disabled
    for (int i = 0; i < 5; i++) bus_write(5'h00, 32'h10 + i);
    rd_chk("status_txovf", 5'h08, 32'h0000_0012);
    bus_write(5'h08, 32'h10);
    rd_chk("status_w1c_txovf", 5'h08, 32'h0000_0002);
    tx_full = 1'b1;
    p0 = push_cnt;
    bus_write(5'h10, 32'h03);
    repeat (6) @(negedge clk);
    check("tx_hold_while_full", push_cnt - p0, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    tx_full = 1'b0;
    wait_tx_drain();
    check("tx_ovf_drain_cnt", push_cnt - p0, 4);

    // RX data read and empty read
    rd_chk("rxdata_good", 5'h04, 32'h0000_0155);
    rd_chk("rxdata_empty", 5'h04, 32'h0);

    // Framing error and interrupt
    bus_write(5'h10, 32'h12);
    check("irq_pre_ferr", irq, 0);
    rx_send(10'b0_1010_1010_0);
    check("irq_with_ferr_edge", irq, 0);
    @(negedge clk);
    check("irq_after_ferr", irq, 1);
    rd_chk("status_ferr", 5'h08, 32'h0000_0045);
    bus_write(5'h08, 32'h40);
    rd_chk("status_ferr_clr", 5'h08, 32'h0000_0005);

    // RX backpressure
    bus_write(5'h10, 32'h02);
    for (int i = 1; i <= 4; i++) rx_send({1'b1, 8'hA0 + 8'(i), 1'b0});
    rd_chk("status_rx_full", 5'h08, 32'h0000_0009);
    @(negedge clk);
    rx_frame = {1'b1, 8'hB5, 1'b0};
    rx_avail = 1'b1;
    gets = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gets += int'(rx_get);
    end
    check("bp_no_get", gets, 0);
    rd_chk("status_rxovf", 5'h08, 32'h0000_0029);
    rd_chk("rx_pop_bp", 5'h04, 32'h0000_01A1);
    found = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rx_get) begin
        found = 1;
        break;
      end
    end
    rx_avail = 1'b0;
    check("bp_get_after_pop", found, 1);
    repeat (3) @(negedge clk);
    rd_chk("status_rx_refull", 5'h08, 32'h0000_0029);
    rd_chk("rx_a2", 5'h04, 32'h0000_01A2);
    rd_chk("rx_a3", 5'h04, 32'h0000_01A3);
    rd_chk("rx_a4", 5'h04, 32'h0000_01A4);
    rd_chk("rx_b5", 5'h04, 32'h0000_01B5);
    rd_chk("status_rx_drained", 5'h08, 32'h0000_0025);

    // Reset in the middle of a transmit push
    bus_write(5'h10, 32'h00);
    bus_write(5'h00, 32'h61);
    bus_write(5'h00, 32'h62);
    bus_write(5'h00, 32'h63);
    exp_q.push_back(8'h61);
    p0 = push_cnt;
    bus_write(5'h10, 32'h01);
    found = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_push) begin
        found = 1;
        break;
      end
    end
    check("midrst_push_seen", found, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_push", tx_push, 0);
    rst = 1'b1;
    rd_chk("midrst_status", 5'h08, 32'h0000_0005);
    p1 = push_cnt;
    repeat (10) @(negedge clk);
    check("midrst_no_more_push", push_cnt - p1, 0);
    check("midrst_total_push", push_cnt - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
